nios_project_led_ctrl: RTL

//  Parametrised Avalon-MM LED output controller; successor to the fixed 10-bit output PIO.

---
 rtl/nios_project_led_ctrl_if.sv | 25 ++
 rtl/nios_project_led_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/nios_project_led_ctrl_if.sv
// Avalon-MM slave bus for the LED controller: register select, write strobe,
// write data and zero-wait-state read data.
interface nios_project_led_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_project_led_ctrl.sv
// LED output controller: DATA register with atomic set/clear, a per-bit blink
// mask and a half-period blink timer, so software never has to toggle LEDs.
//
// Blink timer states (the toggle is a single flop):
//   phase | meaning
//   1     | masked LEDs show DATA (also the idle/reset value)
//   0     | masked LEDs forced off
module nios_project_led_ctrl #(
    parameter int                 WIDTH       = 10,
    parameter int                 PERIOD_W    = 24,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_project_led_ctrl_if.slave avs,
    output logic [WIDTH-1:0]      out_port
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_SET     = 3'd1;
    localparam logic [2:0] ADDR_CLEAR   = 3'd2;
    localparam logic [2:0] ADDR_BLINK   = 3'd3;
    localparam logic [2:0] ADDR_HPERIOD = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    logic [WIDTH-1:0]    data_q,    data_d;
    logic [WIDTH-1:0]    blink_q,   blink_d;
    logic [PERIOD_W-1:0] hperiod_q, hperiod_d;
    logic [PERIOD_W-1:0] cnt_q,     cnt_d;
    logic                phase_q,   phase_d;

    logic                wr_en;
    logic                hp_wr;
    logic [WIDTH-1:0]    wdata_w;

    // Bits above WIDTH/PERIOD_W are deliberately ignored; fold them here.
    logic                unused_wdata;
    assign unused_wdata = ^avs.writedata;

    assign wr_en   = avs.chipselect & ~avs.write_n;
    assign hp_wr   = wr_en && (avs.address == ADDR_HPERIOD);
    assign wdata_w = avs.writedata[WIDTH-1:0];

    // Register-file next state: one register written per cycle at most.
    always_comb begin
        data_d    = data_q;
        blink_d   = blink_q;
        hperiod_d = hperiod_q;
        if (wr_en) begin
            case (avs.address)
                ADDR_DATA:    data_d    = wdata_w;
                ADDR_SET:     data_d    = data_q | wdata_w;
                ADDR_CLEAR:   data_d    = data_q & ~wdata_w;
                ADDR_BLINK:   blink_d   = wdata_w;
                ADDR_HPERIOD: hperiod_d = avs.writedata[PERIOD_W-1:0];
                default:      ;
            endcase
        end
    end

    // Blink timer: an HPERIOD write restarts the timer and beats a terminal count.
    always_comb begin
        cnt_d   = cnt_q + PERIOD_W'(1);
        phase_d = phase_q;
        if (hp_wr || (hperiod_q == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == hperiod_q - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q    <= RESET_VALUE;
            blink_q   <= '0;
            hperiod_q <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
        end else begin
            data_q    <= data_d;
            blink_q   <= blink_d;
            hperiod_q <= hperiod_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Zero-wait-state read mux, zero-extended to the bus width.
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: avs.readdata[WIDTH-1:0]    = data_q;
            ADDR_BLINK:                      avs.readdata[WIDTH-1:0]    = blink_q;
            ADDR_HPERIOD:                    avs.readdata[PERIOD_W-1:0] = hperiod_q;
            ADDR_STATUS:                     avs.readdata[0]            = phase_q;
            default:                         ;
        endcase
    end

    assign out_port = data_q & ~(blink_q & {WIDTH{~phase_q}});

endmodule
